// File: rtl/match_pkg.sv
// Shared types and constants for the two-board match controller.
package match_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PLAY    = 3'd1,
      ST_SEND    = 3'd2,
      ST_WAIT_OP = 3'd3,
      ST_COMPARE = 3'd4,
      ST_RESULT  = 3'd5
   } state_t;

   // ASCII winner codes consumed by the text renderer
   localparam logic [6:0] WIN_NONE = 7'h30;
   localparam logic [6:0] WIN_ME   = 7'h31;
   localparam logic [6:0] WIN_OP   = 7'h32;
   localparam logic [6:0] WIN_TO   = 7'h33;

   localparam logic [6:0] SCORE_MAX = 7'd127;

   // Bit 7 marks a UART byte as a score frame
   localparam int FRAME_BIT = 7;

   // A tie goes to the opponent
   function automatic logic [6:0] pick_winner(input logic [6:0] mine,
                                              input logic [6:0] theirs);
      return (mine > theirs) ? WIN_ME : WIN_OP;
   endfunction

endpackage

// File: rtl/match_controller_prescaler.sv
// One-second prescaler: counts 0..CLK_FREQ_HZ-1 and pulses tick on the wrap cycle.
module sec_prescaler #(
   parameter int CLK_FREQ_HZ = 65_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_FREQ_HZ - 1);

   logic [CW-1:0] count_q;

   // Free-running count, restarted by reset or an explicit clear
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count_q <= '0;
      end else if (count_q == LAST) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + 1'b1;
      end
   end

   // A clear in the wrap cycle suppresses that tick
   assign tick = (count_q == LAST) && !clr;

endmodule

// File: rtl/match_controller.sv
// Round sequencer: scores hits, runs the round timer, sends the local score
// over UART, waits for the opponent score and latches the ASCII winner code.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | after reset, waiting for start
//  ST_PLAY    | round running: hits scored, time_left counts down
//  ST_SEND    | offering {1, my_score} to the UART until accepted
//  ST_WAIT_OP | waiting for the opponent score frame or the timeout
//  ST_COMPARE | one cycle to decide the winner
//  ST_RESULT  | holding winner and score until the next start
module match_controller
   import match_pkg::*;
#(
   parameter int CLK_FREQ_HZ  = 65_000_000,
   parameter int GAME_SECONDS = 30,
   parameter int OP_TIMEOUT_S = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       hit,
   input  logic       tx_ready,
   output logic       tx_valid,
   output logic [7:0] tx_data,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic [6:0] my_score,
   output logic [5:0] time_left,
   output logic       game_active,
   output logic [6:0] winner
);

   state_t     state_q, state_d;
   logic [6:0] my_score_q, my_score_d;
   logic [5:0] time_left_q, time_left_d;
   logic       tx_valid_q, tx_valid_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic [6:0] winner_q, winner_d;
   logic       game_active_q, game_active_d;
   logic       op_valid_q, op_valid_d;
   logic [6:0] op_score_q, op_score_d;
   logic [7:0] to_cnt_q, to_cnt_d;
   logic       presc_clr;
   logic       tick;
   logic       frame;

   sec_prescaler #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ)
   ) u_prescaler (
      .clk (clk),
      .rst (rst),
      .clr (presc_clr),
      .tick(tick)
   );

   assign frame = rx_valid && rx_data[FRAME_BIT];

   // Next-state and next-output decode
   always_comb begin
      state_d     = state_q;
      my_score_d  = my_score_q;
      time_left_d = time_left_q;
      tx_valid_d  = tx_valid_q;
      tx_data_d   = tx_data_q;
      winner_d    = winner_q;
      op_valid_d  = op_valid_q;
      op_score_d  = op_score_q;
      to_cnt_d    = to_cnt_q;
      presc_clr   = 1'b0;

      if (frame && (state_q == ST_PLAY || state_q == ST_SEND || state_q == ST_WAIT_OP)) begin
         op_valid_d = 1'b1;
         op_score_d = rx_data[6:0];
      end

      case (state_q)
         ST_IDLE, ST_RESULT: begin
            if (start) begin
               state_d     = ST_PLAY;
               my_score_d  = '0;
               op_valid_d  = 1'b0;
               presc_clr   = 1'b1;
               time_left_d = 6'(GAME_SECONDS);
               winner_d    = WIN_NONE;
            end
         end
         ST_PLAY: begin
            if (hit && my_score_q != SCORE_MAX) begin
               my_score_d = my_score_q + 7'd1;
            end
            if (tick) begin
               if (time_left_q <= 6'd1) begin
                  // Final second: the hit taken this cycle goes into the frame
                  time_left_d = '0;
                  state_d     = ST_SEND;
                  tx_valid_d  = 1'b1;
                  tx_data_d   = {1'b1, my_score_d};
               end else begin
                  time_left_d = time_left_q - 6'd1;
               end
            end
         end
         ST_SEND: begin
            if (tx_valid_q && tx_ready) begin
               tx_valid_d = 1'b0;
               tx_data_d  = '0;
               state_d    = ST_WAIT_OP;
               presc_clr  = 1'b1;
               to_cnt_d   = 8'(OP_TIMEOUT_S);
            end
         end
         ST_WAIT_OP: begin
            // A frame beats a coincident timeout
            if (op_valid_q || frame) begin
               state_d = ST_COMPARE;
            end else if (tick) begin
               if (to_cnt_q <= 8'd1) begin
                  winner_d = WIN_TO;
                  state_d  = ST_RESULT;
               end else begin
                  to_cnt_d = to_cnt_q - 8'd1;
               end
            end
         end
         ST_COMPARE: begin
            winner_d = pick_winner(my_score_q, op_score_q);
            state_d  = ST_RESULT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      game_active_d = (state_d == ST_PLAY);
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         my_score_q    <= '0;
         time_left_q   <= '0;
         tx_valid_q    <= 1'b0;
         tx_data_q     <= '0;
         winner_q      <= WIN_NONE;
         game_active_q <= 1'b0;
         op_valid_q    <= 1'b0;
         op_score_q    <= '0;
         to_cnt_q      <= '0;
      end else begin
         state_q       <= state_d;
         my_score_q    <= my_score_d;
         time_left_q   <= time_left_d;
         tx_valid_q    <= tx_valid_d;
         tx_data_q     <= tx_data_d;
         winner_q      <= winner_d;
         game_active_q <= game_active_d;
         op_valid_q    <= op_valid_d;
         op_score_q    <= op_score_d;
         to_cnt_q      <= to_cnt_d;
      end
   end

   assign my_score    = my_score_q;
   assign time_left   = time_left_q;
   assign tx_valid    = tx_valid_q;
   assign tx_data     = tx_data_q;
   assign winner      = winner_q;
   assign game_active = game_active_q;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: table-driven rounds, directed corner sequences,
// then random traffic checked against a phase/elapsed-time reference model.
module tb_match_controller;

   localparam int CLK_HZ = 10;
   localparam int GS     = 3;
   localparam int OT     = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       hit = 1'b0;
   logic       tx_ready = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;

   logic       tx_valid, s_tx_valid;
   logic [7:0] tx_data, s_tx_data;
   logic [6:0] my_score, s_my_score;
   logic [5:0] time_left, s_time_left;
   logic       game_active, s_game_active;
   logic [6:0] winner, s_winner;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   match_controller #(.CLK_FREQ_HZ(CLK_HZ), .GAME_SECONDS(GS), .OP_TIMEOUT_S(OT)) dut (
      .clk(clk), .rst(rst), .start(start), .hit(hit), .tx_ready(tx_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .rx_valid(rx_valid), .rx_data(rx_data),
      .my_score(my_score), .time_left(time_left), .game_active(game_active), .winner(winner)
   );

   // Longer round so 130 hits fit inside PLAY
   match_controller #(.CLK_FREQ_HZ(50), .GAME_SECONDS(GS), .OP_TIMEOUT_S(OT)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .hit(hit), .tx_ready(tx_ready),
      .tx_valid(s_tx_valid), .tx_data(s_tx_data), .rx_valid(rx_valid), .rx_data(rx_data),
      .my_score(s_my_score), .time_left(s_time_left), .game_active(s_game_active),
      .winner(s_winner)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: round phases measured in elapsed cycles
   localparam int M_IDLE = 0, M_PLAY = 1, M_SEND = 2, M_WAIT = 3, M_CMP = 4, M_RES = 5;
   int m_phase = M_IDLE, m_el = 0;
   int m_score = 0, m_tl = 0, m_txv = 0, m_txd = 0, m_win = 'h30, m_opv = 0, m_ops = 0;
   int m_ga = 0;
   logic m_frame;

   always @(posedge clk) begin
      m_frame = rx_valid && rx_data[7];
      if (rst) begin
         m_phase = M_IDLE; m_el = 0; m_score = 0; m_tl = 0; m_txv = 0; m_txd = 0;
         m_win = 'h30; m_opv = 0; m_ops = 0;
      end else begin
         if (m_frame && (m_phase == M_PLAY || m_phase == M_SEND || m_phase == M_WAIT)) begin
            m_opv = 1;
            m_ops = int'(rx_data) % 128;
         end
         case (m_phase)
            M_IDLE, M_RES: if (start) begin
               m_phase = M_PLAY; m_el = 0; m_score = 0; m_opv = 0; m_tl = GS; m_win = 'h30;
            end
            M_PLAY: begin
               m_el++;
               if (hit && m_score < 127) m_score++;
               m_tl = GS - m_el / CLK_HZ;
               if (m_el == GS * CLK_HZ) begin
                  m_phase = M_SEND; m_txv = 1; m_txd = 128 + m_score;
               end
            end
            M_SEND: if (m_txv != 0 && tx_ready) begin
               m_txv = 0; m_txd = 0; m_phase = M_WAIT; m_el = 0;
            end
            M_WAIT: begin
               m_el++;
               if (m_opv != 0) m_phase = M_CMP;
               else if (m_el == OT * CLK_HZ) begin
                  m_win = 'h33; m_phase = M_RES;
               end
            end
            M_CMP: begin
               m_win = (m_score > m_ops) ? 'h31 : 'h32;
               m_phase = M_RES;
            end
            default: m_phase = M_IDLE;
         endcase
      end
      m_ga = (m_phase == M_PLAY) ? 1 : 0;
   end

   typedef struct {
      int         hits_first;
      bit         hit_last;
      bit         early_en;
      logic [7:0] early_byte;
      bit         late_en;
      logic [7:0] late_byte;
      int         stall;
      logic [7:0] exp_txd;
      logic [6:0] exp_win;
      int         exp_steps;
   } round_t;

   round_t rounds[7];

   task automatic run_round(input round_t r);
      int steps;
      @(negedge clk); start = 1'b1; tx_ready = 1'b0;
      @(negedge clk); start = 1'b0;
      chk("play_time_left_start", 32'(time_left), GS);
      chk("play_active", 32'(game_active), 1);
      for (int c = 0; c < GS * CLK_HZ; c++) begin
         hit = (c < r.hits_first) || (c == GS * CLK_HZ - 1 && r.hit_last);
         rx_valid = r.early_en && (c == 5);
         rx_data = r.early_byte;
         @(negedge clk);
         if (c == CLK_HZ - 1) chk("time_left_after_1s", 32'(time_left), GS - 1);
      end
      hit = 1'b0; rx_valid = 1'b0;
      chk("send_tx_valid", 32'(tx_valid), 1);
      chk("send_tx_data", 32'(tx_data), 32'(r.exp_txd));
      chk("send_time_left", 32'(time_left), 0);
      chk("send_active", 32'(game_active), 0);
      for (int s = 0; s < r.stall; s++) begin
         @(negedge clk);
         chk("stall_tx_valid", 32'(tx_valid), 1);
         chk("stall_tx_data", 32'(tx_data), 32'(r.exp_txd));
      end
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      chk("post_handshake_tx_valid", 32'(tx_valid), 0);
      rx_valid = r.late_en; rx_data = r.late_byte;
      steps = 0;
      while (winner == 7'h30 && steps < 40) begin
         @(negedge clk);
         rx_valid = 1'b0;
         steps++;
      end
      rx_valid = 1'b0;
      chk("winner_latency", steps, r.exp_steps);
      chk("winner", 32'(winner), 32'(r.exp_win));
      chk("result_score", 32'(my_score), 32'(r.exp_txd[6:0]));
      chk("result_time_left", 32'(time_left), 0);
      @(negedge clk);
      chk("result_hold", 32'(winner), 32'(r.exp_win));
   endtask

   initial begin
      //            hits last early byte   late byte   stall txd    win    steps
      rounds[0] = '{5, 1'b0, 1'b0, 8'h00, 1'b1, 8'h83, 0, 8'h85, 7'h31, 2};
      rounds[1] = '{5, 1'b0, 1'b1, 8'h85, 1'b0, 8'h00, 0, 8'h85, 7'h32, 2};
      rounds[2] = '{5, 1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 0, 8'h85, 7'h33, 20};
      rounds[3] = '{0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 0, 8'h81, 7'h33, 20};
      rounds[4] = '{3, 1'b0, 1'b0, 8'h00, 1'b1, 8'h80, 7, 8'h83, 7'h31, 2};
      rounds[5] = '{2, 1'b0, 1'b1, 8'hFE, 1'b0, 8'h00, 0, 8'h82, 7'h32, 2};
      rounds[6] = '{0, 1'b0, 1'b1, 8'h7F, 1'b0, 8'h00, 0, 8'h80, 7'h33, 20};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_score", 32'(my_score), 0);
      chk("reset_time_left", 32'(time_left), 0);
      chk("reset_tx_valid", 32'(tx_valid), 0);
      chk("reset_tx_data", 32'(tx_data), 0);
      chk("reset_active", 32'(game_active), 0);
      chk("reset_winner", 32'(winner), 'h30);

      foreach (rounds[i]) run_round(rounds[i]);

      // Start during PLAY is ignored, then reset lands mid-SEND
      @(negedge clk); start = 1'b1; tx_ready = 1'b0;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < GS * CLK_HZ; c++) begin
         start = (c == 15);
         hit = (c < 4);
         @(negedge clk);
      end
      start = 1'b0; hit = 1'b0;
      chk("start_in_play_ignored", 32'(tx_valid), 1);
      chk("start_in_play_txd", 32'(tx_data), 'h84);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_send_tx_valid", 32'(tx_valid), 0);
      chk("rst_send_tx_data", 32'(tx_data), 0);
      chk("rst_send_score", 32'(my_score), 0);
      chk("rst_send_winner", 32'(winner), 'h30);
      chk("rst_send_time_left", 32'(time_left), 0);
      chk("rst_send_active", 32'(game_active), 0);

      // Saturation on the long-round instance
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 130; c++) begin
         hit = 1'b1;
         @(negedge clk);
         if (c == 125) chk("sat_score_126", 32'(s_my_score), 126);
      end
      hit = 1'b0;
      chk("sat_score_127", 32'(s_my_score), 127);
      chk("sat_still_active", 32'(s_game_active), 1);

      // Random traffic against the reference model
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         chk("model", {my_score, time_left, game_active, tx_valid, tx_data, winner},
             {7'(m_score), 6'(m_tl), 1'(m_ga), 1'(m_txv), 8'(m_txd), 7'(m_win)});
         rst      = ($urandom_range(0, 399) == 0);
         start    = ($urandom_range(0, 19) == 0);
         hit      = ($urandom_range(0, 1) == 1);
         tx_ready = ($urandom_range(0, 1) == 1);
         rx_valid = ($urandom_range(0, 7) == 0);
         rx_data  = 8'($urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
